uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_BITS, 8, data bits per frame.
- PAR_TYP, 0, parity mode: 0 none, 1 even, 2 odd.
- SB_TICK, 16, stop length in oversample ticks (16 = 1 stop bit).
- FIFO_DEPTH, 16, entries per FIFO (power of 2).
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.

REQ-002 Ports, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx, in, 1, serial input, idle high.
- tx, out, 1, serial output, idle high.
- tx_fifo_wr_en, in, 1, push tx_fifo_din into the TX FIFO.
- tx_fifo_din, in, DATA_BITS, TX write data.
- tx_fifo_full, out, 1, TX FIFO full.
- rx_fifo_rd_en, in, 1, pop the RX FIFO.
- rx_fifo_dout, out, DATA_BITS, RX read data.
- rx_fifo_empty, out, 1, RX FIFO empty.
- rx_error, out, 1, receive error flag.

REQ-003 The following internal signals shall exist with these exact names, for hierarchical probing:
- tx_start, tx_data, tx_done, tx_fifo_empty;
- rx_done, uart_rx_data, rx_fifo_full.

Function
REQ-004 Baud generator shall produce a 1-clk tick every DIV = CLK_FREQ/(BAUD_RATE*16) clks, integer-truncated (54 at the defaults), giving 16 ticks per bit.
REQ-005 Frame format:
- start bit (0);
- DATA_BITS data bits, LSB first;
- parity bit only if PAR_TYP != 0;
- stop high for SB_TICK ticks.
REQ-006 TX FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE drives tx=1.
- Each bit is held 16 ticks.
- PARITY is skipped when PAR_TYP=0.
- tx_done pulses for 1 clk at the end of STOP, then the FSM returns to IDLE.
REQ-007 tx_start shall pulse for 1 clk when the TX FSM is in IDLE and tx_fifo_empty=0.
- The same cycle pops the TX FIFO.
- tx_data carries the popped byte, which TX latches.
- Back-to-back bytes are sent with no idle gap beyond 1-2 clks.
REQ-008 rx shall pass through a 2-FF synchronizer before use.
REQ-009 RX FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE leaves on a synchronized falling edge.
- START samples at tick 7; if the line is high there, return to IDLE (glitch rejected).
- DATA and PARITY sample every 16 ticks.
- STOP waits SB_TICK ticks and samples the stop level.
REQ-010 At the end of STOP, rx_done shall pulse for 1 clk with the assembled byte on uart_rx_data.
REQ-011 Byte disposition on rx_done:
- Good frame (stop=1, parity OK) with rx_fifo_full=0: pushed into the RX FIFO the same cycle.
- Framing error (stop=0) or parity mismatch: byte discarded.
- Good frame with rx_fifo_full=1: byte dropped (overrun).
REQ-012 rx_error shall be registered and pulse high for 1 clk on any framing, parity or overrun event; otherwise 0.
REQ-013 Each FIFO is a synchronous FIFO of FIFO_DEPTH entries:
- wrap-around pointers with an extra bit for full/empty detection;
- push is ignored when full, pop is ignored when empty;
- a simultaneous push and pop on a non-empty, non-full FIFO performs both and leaves the count unchanged.
REQ-014 rx_fifo_dout shall be registered.
- It updates on the clk edge that samples rx_fifo_rd_en=1 with rx_fifo_empty=0.
- Otherwise it holds its last value.
REQ-015 Full/empty flags shall reflect the count after each edge (combinational from the pointers).

Reset
REQ-016 While rst_n=0, asynchronously:
- tx=1, tx_start=0, tx_done=0, rx_done=0, rx_error=0;
- rx_fifo_dout=0;
- both FIFOs empty: rx_fifo_empty=1, tx_fifo_full=0;
- both FSMs in IDLE, baud counter 0.
REQ-017 Reset asserted mid-frame shall abort the frame; no partial byte is sent or stored.
REQ-018 After rst_n rises, the first tick shall occur DIV clks later.

Verification
REQ-019 Loopback (rx=tx), push 0xA5, wait 9000 clks, pulse rx_fifo_rd_en -> rx_fifo_dout=0xA5, rx_fifo_empty=1, rx_error never high.
REQ-020 Loopback, push 0x00, 0xFF, 0x3C, 0x81, 0x5A at 12-clk spacing, wait 45000 clks, pop 5 times -> bytes returned in order, exact values.
REQ-021 Push 17 bytes with tx not consumed (hold in reset-free IDLE by checking within 2 clks) -> tx_fifo_full=1 after 16 entries in FIFO; the 17th push is ignored.
REQ-022 Drive rx externally with stop bit=0 for byte 0x55 -> rx_error pulses 1 clk, rx_fifo_empty stays 1.
REQ-023 Drive a 0.2-bit low glitch on rx -> no rx_done, RX returns to IDLE.
REQ-024 Assert rst_n=0 mid-transmission -> tx=1 immediately, FIFOs empty, no rx_done afterwards.

Source files
------------

// File: rtl/uart_top.sv
// UART with 16x oversampling baud generator, TX/RX FIFOs and
// configurable data bits, parity and stop length.

// Synchronous FIFO with wrap-around pointers; head is the word at the read pointer.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer advance; push ignored when full, pop ignored when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

module uart_top #(
  parameter int DATA_BITS  = 8,
  parameter int PAR_TYP    = 0,
  parameter int SB_TICK    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_fifo_wr_en,
  input  logic [DATA_BITS-1:0] tx_fifo_din,
  output logic                 tx_fifo_full,
  input  logic                 rx_fifo_rd_en,
  output logic [DATA_BITS-1:0] rx_fifo_dout,
  output logic                 rx_fifo_empty,
  output logic                 rx_error
);
  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * 16);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Baud generator
  logic [15:0] baud_cnt;
  logic        tick;

  assign tick = (baud_cnt == 16'(DIV - 1));

  // Free-running divider, one-clk tick at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 16'd1;
  end

  // TX path
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_done;
  logic                 tx_fifo_empty;
  state_t               tx_state;
  logic [7:0]           tx_tick_cnt;
  logic [3:0]           tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_reg;

  assign tx = tx_reg;
  // The tx_done cycle is skipped so the line always shows at least one idle clk.
  assign tx_start = (tx_state == IDLE) && !tx_fifo_empty && !tx_done;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (tx_fifo_wr_en),
    .din   (tx_fifo_din),
    .rd_en (tx_start),
    .head  (tx_data),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty)
  );

  // TX FSM: serialises the popped byte, each bit held for 16 ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shreg    <= '0;
      tx_par      <= 1'b0;
      tx_reg      <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (tx_start) begin
            tx_state    <= START;
            tx_shreg    <= tx_data;
            tx_par      <= (PAR_TYP == 2) ? ~^tx_data : ^tx_data;
            tx_tick_cnt <= '0;
            tx_reg      <= 1'b0;
          end
        end
        START: if (tick) begin
          if (tx_tick_cnt == 8'd15) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_state    <= DATA;
            tx_reg      <= tx_shreg[0];
          end else tx_tick_cnt <= tx_tick_cnt + 8'd1;
        end
        DATA: if (tick) begin
          if (tx_tick_cnt == 8'd15) begin
            tx_tick_cnt <= '0;
            tx_shreg    <= tx_shreg >> 1;
            if (tx_bit_cnt == 4'(DATA_BITS - 1)) begin
              if (PAR_TYP != 0) begin
                tx_state <= PARITY;
                tx_reg   <= tx_par;
              end else begin
                tx_state <= STOP;
                tx_reg   <= 1'b1;
              end
            end else begin
              tx_bit_cnt <= tx_bit_cnt + 4'd1;
              tx_reg     <= tx_shreg[1];
            end
          end else tx_tick_cnt <= tx_tick_cnt + 8'd1;
        end
        PARITY: if (tick) begin
          if (tx_tick_cnt == 8'd15) begin
            tx_tick_cnt <= '0;
            tx_state    <= STOP;
            tx_reg      <= 1'b1;
          end else tx_tick_cnt <= tx_tick_cnt + 8'd1;
        end
        STOP: if (tick) begin
          if (tx_tick_cnt == 8'(SB_TICK - 1)) begin
            tx_state <= IDLE;
            tx_done  <= 1'b1;
          end else tx_tick_cnt <= tx_tick_cnt + 8'd1;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX path
  logic                 rx_done;
  logic [DATA_BITS-1:0] uart_rx_data;
  logic                 rx_fifo_full;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_q;
  logic                 rx_fall;
  state_t               rx_state;
  logic [7:0]           rx_tick_cnt;
  logic [3:0]           rx_bit_cnt;
  logic                 rx_par_bit;
  logic                 rx_par_ok;
  logic                 rx_good;
  logic                 rx_push;
  logic [DATA_BITS-1:0] rx_head;

  assign rx_fall   = rx_q && !rx_s2;
  assign rx_par_ok = (PAR_TYP == 0) || (((^uart_rx_data) ^ rx_par_bit) == (PAR_TYP == 2));
  assign rx_push   = rx_done && rx_good && !rx_fifo_full;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // RX FSM: mid-bit sampling; stop level and parity are judged together at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= IDLE;
      rx_tick_cnt  <= '0;
      rx_bit_cnt   <= '0;
      uart_rx_data <= '0;
      rx_par_bit   <= 1'b0;
      rx_good      <= 1'b0;
      rx_done      <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        IDLE: if (rx_fall) begin
          rx_state    <= START;
          rx_tick_cnt <= '0;
        end
        START: if (tick) begin
          if (rx_tick_cnt == 8'd7) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_state    <= rx_s2 ? IDLE : DATA;
          end else rx_tick_cnt <= rx_tick_cnt + 8'd1;
        end
        DATA: if (tick) begin
          if (rx_tick_cnt == 8'd15) begin
            rx_tick_cnt  <= '0;
            uart_rx_data <= {rx_s2, uart_rx_data[DATA_BITS-1:1]};
            if (rx_bit_cnt == 4'(DATA_BITS - 1)) rx_state <= (PAR_TYP != 0) ? PARITY : STOP;
            else                                  rx_bit_cnt <= rx_bit_cnt + 4'd1;
          end else rx_tick_cnt <= rx_tick_cnt + 8'd1;
        end
        PARITY: if (tick) begin
          if (rx_tick_cnt == 8'd15) begin
            rx_tick_cnt <= '0;
            rx_par_bit  <= rx_s2;
            rx_state    <= STOP;
          end else rx_tick_cnt <= rx_tick_cnt + 8'd1;
        end
        STOP: if (tick) begin
          if (rx_tick_cnt == 8'(SB_TICK - 1)) begin
            rx_done  <= 1'b1;
            rx_good  <= rx_s2 && rx_par_ok;
            rx_state <= IDLE;
          end else rx_tick_cnt <= rx_tick_cnt + 8'd1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (rx_push),
    .din   (uart_rx_data),
    .rd_en (rx_fifo_rd_en),
    .head  (rx_head),
    .full  (rx_fifo_full),
    .empty (rx_fifo_empty)
  );

  // Registered read port and one-clk error pulse for framing/parity/overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_fifo_dout <= '0;
      rx_error     <= 1'b0;
    end else begin
      if (rx_fifo_rd_en && !rx_fifo_empty) rx_fifo_dout <= rx_head;
      rx_error <= rx_done && (!rx_good || rx_fifo_full);
    end
  end
endmodule

// File: tb/tb_uart_top.sv
// Directed/randomised bench for uart_top at default parameters.
module tb_uart_top;
  localparam int BIT = 16 * 54;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx;
  logic       wr_en = 1'b0;
  logic [7:0] din = '0;
  logic       full;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic       rx_error;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_hi = 0;
  int err_rise = 0;
  logic err_q = 1'b0;
  logic [7:0] last_rx = '0;
  logic [7:0] exp_q[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_top dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .tx            (tx),
    .tx_fifo_wr_en (wr_en),
    .tx_fifo_din   (din),
    .tx_fifo_full  (full),
    .rx_fifo_rd_en (rd_en),
    .rx_fifo_dout  (dout),
    .rx_fifo_empty (empty),
    .rx_error      (rx_error)
  );

  always #5 clk = ~clk;

  // Event monitor: receive completions and error pulse shape.
  always @(posedge clk) begin
    if (dut.rx_done) begin
      done_cnt++;
      last_rx = dut.uart_rx_data;
    end
    if (rx_error) err_hi++;
    if (rx_error && !err_q) err_rise++;
    err_q = rx_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    din = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      clks(BIT);
    end
    rx_drv = stop;
    clks(BIT);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [7:0] d;
    int base_done;
    int base_hi;
    int base_rise;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C; burst[3] = 8'h81; burst[4] = 8'h5A;

    // Reset state
    clks(3);
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", dout, 0);
    check("rst_err", rx_error, 0);
    check("rst_txstart", dut.tx_start, 0);
    rst_n = 1'b1;
    clks(5);

    // Single loopback byte, then a pop on an empty FIFO must hold the output
    loop_en = 1'b1;
    push(8'hA5);
    exp_q.push_back(8'hA5);
    clks(9000);
    pop();
    check("lb1_data", dout, exp_q.pop_front());
    check("lb1_empty", empty, 1);
    check("lb1_done", done_cnt, 1);
    check("lb1_noerr", err_hi, 0);
    pop();
    check("pop_empty_hold", dout, 8'hA5);

    // Five-byte burst at 12-clk spacing
    for (int i = 0; i < 5; i++) begin
      push(burst[i]);
      exp_q.push_back(burst[i]);
      clks(11);
    end
    clks(45000);
    for (int i = 0; i < 5; i++) begin
      pop();
      check("burst_data", dout, exp_q.pop_front());
    end
    check("burst_empty", empty, 1);
    check("burst_noerr", err_hi, 0);

    // Random byte through the loop
    d = 8'($urandom_range(0, 255));
    push(d);
    exp_q.push_back(d);
    clks(9000);
    pop();
    check("rand_data", dout, exp_q.pop_front());
    check("rand_empty", empty, 1);

    // Fill TX FIFO while the transmitter is busy, then reset mid-frame
    push(8'h11);
    clks(1);
    check("tx_took_first", dut.tx_fifo_empty, 1);
    for (int i = 1; i <= 16; i++) begin
      push(8'($urandom_range(0, 255)));
      if (i == 15) check("full_at_15", full, 0);
    end
    check("full_at_16", full, 1);
    push(8'hEE);
    check("full_after_17", full, 1);
    check("fifo_not_wrapped", dut.tx_fifo_empty, 0);
    base_done = done_cnt;
    clks(3000);
    check("tx_midframe_bit2", tx, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_full", full, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_dout", dout, 0);
    clks(3);
    rst_n = 1'b1;
    clks(2000);
    check("post_rst_nodone", done_cnt, base_done);
    check("post_rst_tx", tx, 1);
    check("post_rst_txempty", dut.tx_fifo_empty, 1);
    check("post_rst_rxempty", empty, 1);

    // Glitch shorter than half a bit is rejected
    loop_en = 1'b0;
    rx_drv = 1'b1;
    clks(20);
    base_done = done_cnt;
    rx_drv = 1'b0;
    clks(173);
    rx_drv = 1'b1;
    clks(2000);
    check("glitch_nodone", done_cnt, base_done);
    check("glitch_empty", empty, 1);
    check("glitch_noerr", err_hi, 0);

    // Framing error on 0x55: one-clk error pulse, nothing stored
    base_hi = err_hi;
    base_rise = err_rise;
    send_frame(8'h55, 1'b0);
    clks(200);
    check("frm_done", done_cnt, base_done + 1);
    check("frm_data", last_rx, 8'h55);
    check("frm_err_pulses", err_rise - base_rise, 1);
    check("frm_err_width", err_hi - base_hi, 1);
    check("frm_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
